// File: rtl/player_turn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : player_turn_arbiter
// Description : Shares the cursor/paddle control and the rgb activity
//               indicator between two players. Both switch ports are sampled
//               once per video frame, the fire buttons are debounced, and
//               control is granted round-robin with an optional per-turn
//               frame limit.
// Options     : TURN_TIMEOUT_EN - when defined, a turn lasts at most
//               TURN_FRAMES frames under contention; when undefined, the grant
//               holds until the owner releases fire.
// Revision    : 1.0 - initial release
// ============================================================================
module player_turn_arbiter #(
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned TURN_FRAMES     = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync_i,
  input  logic       display_on_i,
  input  logic [7:0] switches_p1_i,
  input  logic [7:0] switches_p2_i,
  output logic [1:0] grant_o,
  output logic [7:0] active_switches_o,
  output logic [7:0] turn_frames_left_o,
  output logic       turn_start_o,
  output logic [2:0] rgb_o
);

  localparam int unsigned FIRE_BIT = 4;
  localparam logic [3:0]  DEB_MAX  = 4'(DEBOUNCE_FRAMES);

`ifdef TURN_TIMEOUT_EN
  localparam logic [7:0]  TURN_LOAD = 8'(TURN_FRAMES);
`else
  // Without the turn limit the counter is pinned at zero.
  localparam logic [7:0]  TURN_LOAD = 8'd0;
  logic unused_turn_frames;
  assign unused_turn_frames = ^TURN_FRAMES;
`endif

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_P1 = 2'd1,
    ST_GRANT_P2 = 2'd2,
    ST_HANDOFF  = 2'd3
  } state_t;

  state_t     state_q;
  logic       vsync_prev_q;
  logic       tick_q;
  logic [3:0] deb_p1_q, deb_p2_q;
  logic [3:0] deb_p1_d, deb_p2_d;
  logic       req_p1_d, req_p2_d;
  logic       pick_p1, pick_p2;
  logic       last_p2_q;
  logic [1:0] grant_q;
  logic [7:0] active_q;
  logic [7:0] turn_left_q;
  logic       turn_start_q;

  // Debounce step: count up while fire is held, saturate, clear on release.
  function automatic logic [3:0] deb_next(input logic [3:0] cnt, input logic fire);
    if (!fire)               return 4'd0;
    else if (cnt == DEB_MAX) return cnt;
    else                     return cnt + 4'd1;
  endfunction

  // Frame tick: registered rising-edge detect of vsync. The previous-vsync
  // register resets high so a vsync already high at reset release is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev_q <= 1'b1;
      tick_q       <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_i;
      tick_q       <= vsync_i & ~vsync_prev_q;
    end
  end

  // Requests use the counter value produced by this tick, so a grant can be
  // issued on the same tick the debounce count completes.
  always_comb begin
    deb_p1_d = deb_next(deb_p1_q, switches_p1_i[FIRE_BIT]);
    deb_p2_d = deb_next(deb_p2_q, switches_p2_i[FIRE_BIT]);
    req_p1_d = (deb_p1_d == DEB_MAX);
    req_p2_d = (deb_p2_d == DEB_MAX);
    // Round-robin: on contention the player who did not own the last turn wins.
    pick_p1  = req_p1_d & (~req_p2_d | last_p2_q);
    pick_p2  = req_p2_d & (~req_p1_d | ~last_p2_q);
  end

  // Per-player debounce counters, advanced only on frame ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_p1_q <= 4'd0;
      deb_p2_q <= 4'd0;
    end else if (tick_q) begin
      deb_p1_q <= deb_p1_d;
      deb_p2_q <= deb_p2_d;
    end
  end

  // Turn FSM with registered outputs; switches are sampled on the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      active_q     <= 8'd0;
      turn_left_q  <= 8'd0;
      turn_start_q <= 1'b0;
      last_p2_q    <= 1'b1;
    end else begin
      turn_start_q <= 1'b0;
      if (tick_q) begin
        case (state_q)
          ST_GRANT_P1: begin
            if (!req_p1_d) begin
              state_q     <= ST_HANDOFF;
              grant_q     <= 2'b00;
              active_q    <= 8'd0;
              turn_left_q <= 8'd0;
`ifdef TURN_TIMEOUT_EN
            end else if (turn_left_q == 8'd1 && req_p2_d) begin
              state_q     <= ST_HANDOFF;
              grant_q     <= 2'b00;
              active_q    <= 8'd0;
              turn_left_q <= 8'd0;
            end else if (turn_left_q == 8'd1) begin
              turn_left_q <= TURN_LOAD;
              active_q    <= switches_p1_i;
            end else begin
              turn_left_q <= turn_left_q - 8'd1;
              active_q    <= switches_p1_i;
            end
`else
            end else begin
              active_q    <= switches_p1_i;
            end
`endif
          end
          ST_GRANT_P2: begin
            if (!req_p2_d) begin
              state_q     <= ST_HANDOFF;
              grant_q     <= 2'b00;
              active_q    <= 8'd0;
              turn_left_q <= 8'd0;
`ifdef TURN_TIMEOUT_EN
            end else if (turn_left_q == 8'd1 && req_p1_d) begin
              state_q     <= ST_HANDOFF;
              grant_q     <= 2'b00;
              active_q    <= 8'd0;
              turn_left_q <= 8'd0;
            end else if (turn_left_q == 8'd1) begin
              turn_left_q <= TURN_LOAD;
              active_q    <= switches_p2_i;
            end else begin
              turn_left_q <= turn_left_q - 8'd1;
              active_q    <= switches_p2_i;
            end
`else
            end else begin
              active_q    <= switches_p2_i;
            end
`endif
          end
          // IDLE and HANDOFF evaluate identically, so the handoff gap is one frame.
          default: begin
            if (pick_p1) begin
              state_q      <= ST_GRANT_P1;
              grant_q      <= 2'b01;
              active_q     <= switches_p1_i;
              turn_left_q  <= TURN_LOAD;
              turn_start_q <= 1'b1;
              last_p2_q    <= 1'b0;
            end else if (pick_p2) begin
              state_q      <= ST_GRANT_P2;
              grant_q      <= 2'b10;
              active_q     <= switches_p2_i;
              turn_left_q  <= TURN_LOAD;
              turn_start_q <= 1'b1;
              last_p2_q    <= 1'b1;
            end else begin
              state_q      <= ST_IDLE;
              grant_q      <= 2'b00;
              active_q     <= 8'd0;
              turn_left_q  <= 8'd0;
            end
          end
        endcase
      end
    end
  end

  // Activity colour: red for P1, blue for P2, green when free, black off-screen.
  always_comb begin
    rgb_o = 3'b000;
    if (display_on_i) begin
      case (grant_q)
        2'b01:   rgb_o = 3'b100;
        2'b10:   rgb_o = 3'b001;
        default: rgb_o = 3'b010;
      endcase
    end
  end

  assign grant_o            = grant_q;
  assign active_switches_o  = active_q;
  assign turn_frames_left_o = turn_left_q;
  assign turn_start_o       = turn_start_q;

endmodule
`default_nettype wire

// File: tb/tb_player_turn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_turn_arbiter
// Description : Directed bench for player_turn_arbiter; a frame-by-frame
//               vector table plus hand-written multi-frame sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_turn_arbiter;

`ifdef TURN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       display_on = 1'b1;
  logic [7:0] sw1 = 8'd0;
  logic [7:0] sw2 = 8'd0;
  logic [1:0] grant;
  logic [7:0] active_sw;
  logic [7:0] tfl;
  logic       tstart;
  logic [2:0] rgb;

  int total = 0;
  int bad   = 0;

  player_turn_arbiter #(.DEBOUNCE_FRAMES(3), .TURN_FRAMES(60)) dut (
    .clk                (clk),
    .reset              (reset),
    .vsync_i            (vsync),
    .display_on_i       (display_on),
    .switches_p1_i      (sw1),
    .switches_p2_i      (sw2),
    .grant_o            (grant),
    .active_switches_o  (active_sw),
    .turn_frames_left_o (tfl),
    .turn_start_o       (tstart),
    .rgb_o              (rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s1;
    logic [7:0] s2;
    logic [1:0] g;
    logic [7:0] act;
    logic       ts;
    logic [7:0] tfl;
    logic       chk_tfl;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_rgb(input logic [1:0] g);
    if (g == 2'b01)      return 3'b100;
    else if (g == 2'b10) return 3'b001;
    else                 return 3'b010;
  endfunction

  // One video frame: vsync pulse, then return once the tick's results are visible.
  task automatic frame(input logic [7:0] s1, input logic [7:0] s2);
    @(negedge clk);
    sw1   = s1;
    sw2   = s2;
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    vsync = 1'b0;
    sw1   = 8'd0;
    sw2   = 8'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_all(input string name, input logic [1:0] g, input logic [7:0] act,
                         input logic ts, input logic [7:0] t, input logic do_tfl);
    chk({name, ".grant"}, 32'(grant), 32'(g));
    chk({name, ".active"}, 32'(active_sw), 32'(act));
    chk({name, ".turn_start"}, 32'(tstart), 32'(ts));
    chk({name, ".rgb"}, 32'(rgb), 32'(exp_rgb(g)));
    if (do_tfl) chk({name, ".tfl"}, 32'(tfl), 32'(TO_EN ? t : 8'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] e_tfl;
    int         starts;

    // s1, s2, grant, active, turn_start, tfl (timeout build), check tfl
    vecs[0]  = '{8'h00, 8'h15, 2'b00, 8'h00, 1'b0, 8'd0,  1'b1};
    vecs[1]  = '{8'h00, 8'h15, 2'b00, 8'h00, 1'b0, 8'd0,  1'b1};
    vecs[2]  = '{8'h00, 8'h05, 2'b00, 8'h00, 1'b0, 8'd0,  1'b1};
    vecs[3]  = '{8'h13, 8'h00, 2'b00, 8'h00, 1'b0, 8'd0,  1'b1};
    vecs[4]  = '{8'h13, 8'h00, 2'b00, 8'h00, 1'b0, 8'd0,  1'b1};
    vecs[5]  = '{8'h13, 8'h00, 2'b01, 8'h13, 1'b1, 8'd60, 1'b1};
    vecs[6]  = '{8'h1C, 8'h00, 2'b01, 8'h1C, 1'b0, 8'd59, 1'b1};
    vecs[7]  = '{8'h0C, 8'h00, 2'b00, 8'h00, 1'b0, 8'd0,  1'b0};
    vecs[8]  = '{8'h13, 8'h00, 2'b00, 8'h00, 1'b0, 8'd0,  1'b0};
    vecs[9]  = '{8'h00, 8'h15, 2'b00, 8'h00, 1'b0, 8'd0,  1'b0};
    vecs[10] = '{8'h00, 8'h15, 2'b00, 8'h00, 1'b0, 8'd0,  1'b0};
    vecs[11] = '{8'h00, 8'h17, 2'b10, 8'h17, 1'b1, 8'd60, 1'b1};
    vecs[12] = '{8'h13, 8'h17, 2'b10, 8'h17, 1'b0, 8'd59, 1'b1};
    vecs[13] = '{8'h13, 8'h17, 2'b10, 8'h17, 1'b0, 8'd58, 1'b1};
    vecs[14] = '{8'h13, 8'h06, 2'b00, 8'h00, 1'b0, 8'd0,  1'b0};
    vecs[15] = '{8'h13, 8'h00, 2'b01, 8'h13, 1'b1, 8'd60, 1'b1};

    // Reset state, including rgb with and without the visible area.
    do_reset();
    chk_all("reset", 2'b00, 8'h00, 1'b0, 8'd0, 1'b1);
    display_on = 1'b0;
    #1;
    chk("reset.rgb_blank", 32'(rgb), 32'd0);
    display_on = 1'b1;

    // Frame-by-frame vector table.
    for (int i = 0; i < 16; i++) begin
      frame(vecs[i].s1, vecs[i].s2);
      chk_all($sformatf("vec%0d", i), vecs[i].g, vecs[i].act, vecs[i].ts,
              vecs[i].tfl, vecs[i].chk_tfl);
    end
    @(negedge clk);
    chk("vec_pulse_end", 32'(tstart), 32'd0);
    display_on = 1'b0;
    #1;
    chk("vec_rgb_blank", 32'(rgb), 32'd0);
    display_on = 1'b1;

    // Contention from the same tick: P1 wins first, then P2 takes over.
    do_reset();
    frame(8'h10, 8'h10);
    frame(8'h10, 8'h10);
    frame(8'h10, 8'h10);
    chk_all("cont.first", 2'b01, 8'h10, 1'b1, 8'd60, 1'b1);
    if (TO_EN) begin
      for (int k = 1; k < 60; k++) begin
        frame(8'h10, 8'h10);
        chk("cont.hold_grant", 32'(grant), 32'd1);
      end
      chk("cont.last_frame_tfl", 32'(tfl), 32'd1);
      frame(8'h10, 8'h10);
      chk_all("cont.timeout", 2'b00, 8'h00, 1'b0, 8'd0, 1'b0);
      frame(8'h10, 8'h10);
      chk_all("cont.p2", 2'b10, 8'h10, 1'b1, 8'd60, 1'b1);
    end else begin
      frame(8'h10, 8'h10);
      frame(8'h10, 8'h10);
      chk("cont.still_p1", 32'(grant), 32'd1);
      frame(8'h00, 8'h10);
      chk_all("cont.release", 2'b00, 8'h00, 1'b0, 8'd0, 1'b0);
      frame(8'h00, 8'h10);
      chk_all("cont.p2", 2'b10, 8'h10, 1'b1, 8'd0, 1'b1);
    end

    // P1 alone for 130 frames: never loses the grant, no extra turn_start.
    do_reset();
    frame(8'h10, 8'h00);
    frame(8'h10, 8'h00);
    frame(8'h10, 8'h00);
    chk_all("solo.grant", 2'b01, 8'h10, 1'b1, 8'd60, 1'b1);
    e_tfl  = 8'd60;
    starts = 0;
    for (int k = 0; k < 130; k++) begin
      frame(8'h10, 8'h00);
      e_tfl = (e_tfl == 8'd1) ? 8'd60 : e_tfl - 8'd1;
      if (tstart) starts++;
      chk("solo.grant_hold", 32'(grant), 32'd1);
      chk("solo.tfl", 32'(tfl), 32'(TO_EN ? e_tfl : 8'd0));
    end
    chk("solo.no_restart", 32'(starts), 32'd0);

    // vsync already high when reset deasserts: no tick until a fresh edge.
    @(negedge clk);
    reset = 1'b1;
    vsync = 1'b1;
    sw1   = 8'h10;
    sw2   = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("vsh.no_tick", 32'(grant), 32'd0);
    vsync = 1'b0;
    @(negedge clk);
    frame(8'h10, 8'h00);
    frame(8'h10, 8'h00);
    chk("vsh.two_frames", 32'(grant), 32'd0);
    frame(8'h10, 8'h00);
    chk_all("vsh.grant", 2'b01, 8'h10, 1'b1, 8'd60, 1'b1);

    // Reset mid-turn while P2 owns the resource.
    do_reset();
    frame(8'h00, 8'h12);
    frame(8'h00, 8'h12);
    frame(8'h00, 8'h12);
    chk_all("mid.p2", 2'b10, 8'h12, 1'b1, 8'd60, 1'b1);
    for (int k = 0; k < 43; k++) frame(8'h00, 8'h12);
    chk_all("mid.before", 2'b10, 8'h12, 1'b0, 8'd17, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    vsync = 1'b1;
    @(negedge clk);
    chk_all("mid.after", 2'b00, 8'h00, 1'b0, 8'd0, 1'b1);
    reset = 1'b0;
    vsync = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
